// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-bus signals of the load/store unit.
// The unit takes the slave view; the pipeline plus bus environment takes the master view.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic [1:0]            resp_exc;
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W/8-1:0]   bus_be;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_ack;
  logic [DATA_W-1:0]     bus_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, bus_ack, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_exc,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, bus_ack, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: alignment/size checks, byte-lane steering, req/ack bus
// handshake with optional timeout, and load extension returned as a one-cycle response.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  mem_access_unit_if.slave io
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;
  localparam logic [1:0] EXC_SIZE     = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        exc_q, exc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              in_bus, misalign, bad_size, sign_bit;
  logic [OFF_W-1:0]  off;
  logic [7:0]        mask8;
  logic [DATA_W-1:0] shifted, keep, ext;

  assign in_bus   = (state_q == S_BUS);
  assign off      = addr_q[OFF_W-1:0];
  assign bad_size = (io.req_size == 2'd3) && (DATA_W == 32);

  always_comb begin
    case (io.req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = io.req_addr[0];
      2'd2:    misalign = |io.req_addr[1:0];
      default: misalign = |io.req_addr[2:0];
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    mask8 = 8'h01;
      2'd1:    mask8 = 8'h03;
      2'd2:    mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
  end

  // Extension works on the lane-shifted word; a dword keeps all bits and never sign-extends.
  always_comb begin
    shifted  = io.bus_rdata >> {off, 3'b000};
    keep     = '1;
    sign_bit = 1'b0;
    case (size_q)
      2'd0:    begin keep = DATA_W'(8'hFF);         sign_bit = shifted[7];  end
      2'd1:    begin keep = DATA_W'(16'hFFFF);      sign_bit = shifted[15]; end
      2'd2:    begin keep = DATA_W'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: ;
    endcase
    ext = (shifted & keep) | ((sgn_q && sign_bit) ? ~keep : '0);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sgn_d   = sgn_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    exc_d   = exc_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (io.req_valid) begin
          we_d    = io.req_we;
          sgn_d   = io.req_signed;
          size_d  = io.req_size;
          addr_d  = io.req_addr;
          wdata_d = io.req_wdata;
          cnt_d   = '0;
          if (bad_size) begin
            state_d = S_RESP;
            exc_d   = EXC_SIZE;
            rdata_d = '0;
          end else if (misalign) begin
            state_d = S_RESP;
            exc_d   = EXC_MISALIGN;
            rdata_d = '0;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // An ack arriving in the last allowed cycle takes priority over the timeout.
        if (io.bus_ack) begin
          state_d = S_RESP;
          exc_d   = EXC_NONE;
          rdata_d = we_q ? '0 : ext;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_RESP;
          exc_d   = EXC_TIMEOUT;
          rdata_d = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      exc_q   <= EXC_NONE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sgn_q   <= sgn_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs are gated by state so a reset mid-access clears them without a clock edge.
  assign io.req_ready  = (state_q == S_IDLE);
  assign io.resp_valid = (state_q == S_RESP);
  assign io.resp_rdata = rdata_q;
  assign io.resp_exc   = exc_q;
  assign io.bus_req    = in_bus;
  assign io.bus_we     = in_bus & we_q;
  assign io.bus_addr   = in_bus ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign io.bus_be     = in_bus ? (BE_W'(mask8) << off) : '0;
  assign io.bus_wdata  = in_bus ? (wdata_q << {off, 3'b000}) : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a 32-bit and a 64-bit instance behind a shared
// stimulus/observation mux, with expected responses queued at request time.
module tb_mem_access_unit;
  localparam int TO = 4;

  typedef struct packed {
    logic [63:0] rd;
    logic [1:0]  exc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic t_valid = 1'b0, t_we = 1'b0, t_sg = 1'b0, t_ack = 1'b0;
  logic [1:0]  t_sz = 2'd0;
  logic [31:0] t_addr = '0;
  logic [63:0] t_wd = '0, t_rd = '0;

  int chk_cnt = 0;
  int pass_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) m32();
  mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) m64();

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) u32 (.clk(clk), .reset(reset), .io(m32));
  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(TO)) u64 (.clk(clk), .reset(reset), .io(m64));

  assign m32.req_valid  = t_valid & ~sel;
  assign m32.req_we     = t_we;
  assign m32.req_size   = t_sz;
  assign m32.req_signed = t_sg;
  assign m32.req_addr   = t_addr;
  assign m32.req_wdata  = t_wd[31:0];
  assign m32.bus_ack    = t_ack & ~sel;
  assign m32.bus_rdata  = t_rd[31:0];
  assign m64.req_valid  = t_valid & sel;
  assign m64.req_we     = t_we;
  assign m64.req_size   = t_sz;
  assign m64.req_signed = t_sg;
  assign m64.req_addr   = t_addr;
  assign m64.req_wdata  = t_wd;
  assign m64.bus_ack    = t_ack & sel;
  assign m64.bus_rdata  = t_rd;

  logic        o_ready, o_rvalid, o_breq, o_bwe;
  logic [1:0]  o_exc;
  logic [31:0] o_baddr;
  logic [7:0]  o_bbe;
  logic [63:0] o_rdata, o_bwd;
  assign o_ready  = sel ? m64.req_ready  : m32.req_ready;
  assign o_rvalid = sel ? m64.resp_valid : m32.resp_valid;
  assign o_rdata  = sel ? m64.resp_rdata : {32'h0, m32.resp_rdata};
  assign o_exc    = sel ? m64.resp_exc   : m32.resp_exc;
  assign o_breq   = sel ? m64.bus_req    : m32.bus_req;
  assign o_bwe    = sel ? m64.bus_we     : m32.bus_we;
  assign o_baddr  = sel ? m64.bus_addr   : m32.bus_addr;
  assign o_bbe    = sel ? m64.bus_be     : {4'h0, m32.bus_be};
  assign o_bwd    = sel ? m64.bus_wdata  : {32'h0, m32.bus_wdata};

  function automatic logic [63:0] m_load(input logic [63:0] rd, input int off, input int sz,
                                         input bit sg, input int nb);
    int n;
    logic [63:0] r;
    n = 1 << sz;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = rd[8*(off+i) +: 8];
    if (sg && sz < 3 && r[8*n-1]) for (int i = 8*n; i < 64; i++) r[i] = 1'b1;
    if (nb == 4) r[63:32] = '0;
    return r;
  endfunction

  function automatic logic [7:0] m_be(input int off, input int sz);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < (1 << sz); i++) b[off+i] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] m_wd(input logic [63:0] wd, input int off, input int nb);
    logic [63:0] r;
    r = '0;
    for (int i = off; i < nb; i++) r[8*i +: 8] = wd[8*(i-off) +: 8];
    return r;
  endfunction

  task automatic access(input string nm, input bit s, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [63:0] rd, input int wait_n, input logic [31:0] e_addr,
                        input logic [7:0] e_be, input logic [63:0] e_wd,
                        input logic [63:0] e_rd, input logic [1:0] e_exc);
    int bcyc, e_bcyc;
    exp_t e;
    e_bcyc = (e_exc == 2'd1 || e_exc == 2'd3) ? 0 : ((wait_n >= TO) ? TO : wait_n + 1);
    sel = s;
    @(negedge clk);
    chk_cnt++;
    if (o_ready !== 1'b1) $display("FAIL %s ready_before: got %b want 1", nm, o_ready);
    else pass_cnt++;
    t_valid = 1'b1; t_we = we; t_sz = sz; t_sg = sg; t_addr = addr; t_wd = wd;
    sb.push_back('{rd: e_rd, exc: e_exc});
    @(negedge clk);
    t_valid = 1'b0;
    bcyc = 0;
    while (o_breq === 1'b1 && bcyc < 40) begin
      chk_cnt++;
      if ({o_bwe, o_baddr, o_bbe, o_bwd} !== {we, e_addr, e_be, e_wd})
        $display("FAIL %s bus_fields: got we=%b addr=%h be=%h wd=%h want we=%b addr=%h be=%h wd=%h",
                 nm, o_bwe, o_baddr, o_bbe, o_bwd, we, e_addr, e_be, e_wd);
      else pass_cnt++;
      chk_cnt++;
      if (o_ready !== 1'b0) $display("FAIL %s ready_busy: got %b want 0", nm, o_ready);
      else pass_cnt++;
      if (bcyc == wait_n) begin t_ack = 1'b1; t_rd = rd; end
      @(negedge clk);
      t_ack = 1'b0; t_rd = '0;
      bcyc++;
    end
    chk_cnt++;
    if (bcyc != e_bcyc) $display("FAIL %s bus_req_cycles: got %0d want %0d", nm, bcyc, e_bcyc);
    else pass_cnt++;
    chk_cnt++;
    if (o_rvalid !== 1'b1) $display("FAIL %s resp_valid: got %b want 1", nm, o_rvalid);
    else pass_cnt++;
    e = sb.pop_front();
    chk_cnt++;
    if ({o_rdata, o_exc} !== {e.rd, e.exc})
      $display("FAIL %s resp: got rdata=%h exc=%0d want rdata=%h exc=%0d", nm, o_rdata, o_exc, e.rd, e.exc);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({o_rvalid, o_ready} !== 2'b01)
      $display("FAIL %s resp_end: got valid=%b ready=%b want 0 1", nm, o_rvalid, o_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({m32.req_ready, m64.req_ready} !== 2'b11)
      $display("FAIL reset_ready: got %b want 11", {m32.req_ready, m64.req_ready});
    else pass_cnt++;
    chk_cnt++;
    if ({m32.resp_valid, m32.resp_rdata, m32.resp_exc, m32.bus_req, m32.bus_we, m32.bus_addr,
         m32.bus_be, m32.bus_wdata, m64.resp_valid, m64.resp_rdata, m64.resp_exc, m64.bus_req,
         m64.bus_we, m64.bus_addr, m64.bus_be, m64.bus_wdata} !== '0)
      $display("FAIL reset_outputs: got nonzero output want all zero");
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_load_byte();
    access("lb_signed", 0, 0, 2'd0, 1, 32'h1003, 64'h0, 64'h80FF_FFFF, 0,
           32'h1000, 8'h08, 64'h0, 64'hFFFF_FF80, 2'd0);
  endtask

  task automatic test_store_half();
    access("sh_wait3", 0, 1, 2'd1, 0, 32'h2002, 64'h0000_ABCD, 64'h1111_2222, 3,
           32'h2000, 8'h0C, 64'hABCD_0000, 64'h0, 2'd0);
  endtask

  task automatic test_exceptions();
    access("misalign_lw", 0, 0, 2'd2, 0, 32'h3002, 64'h0, 64'h0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd1);
    access("dword_on_32", 0, 0, 2'd3, 0, 32'h3000, 64'h0, 64'h0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd3);
    access("misalign_sd64", 1, 1, 2'd3, 0, 32'h4004, 64'h5, 64'h0, 0, 32'h0, 8'h0, 64'h0, 64'h0, 2'd1);
  endtask

  task automatic test_timeout();
    access("timeout", 0, 0, 2'd2, 1, 32'h5000, 64'h0, 64'hDEAD_BEEF, 99,
           32'h5000, 8'h0F, 64'h0, 64'h0, 2'd2);
    access("ack_last", 0, 0, 2'd2, 1, 32'h5004, 64'h0, 64'h1234_5678, 3,
           32'h5004, 8'h0F, 64'h0, 64'h1234_5678, 2'd0);
  endtask

  task automatic test_wide();
    access("lw64_u", 1, 0, 2'd2, 0, 32'h4004, 64'h0, 64'h8765_4321_0000_0000, 0,
           32'h4000, 8'hF0, 64'h0, 64'h0000_0000_8765_4321, 2'd0);
    access("lw64_s", 1, 0, 2'd2, 1, 32'h4004, 64'h0, 64'h8765_4321_0000_0000, 1,
           32'h4000, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321, 2'd0);
    access("ld64_s", 1, 0, 2'd3, 1, 32'h4008, 64'h0, 64'h8000_0000_0000_0001, 2,
           32'h4008, 8'hFF, 64'h0, 64'h8000_0000_0000_0001, 2'd0);
  endtask

  task automatic test_lanes();
    for (int s = 0; s < 2; s++) begin
      for (int sz = 0; sz <= (s ? 3 : 2); sz++) begin
        for (int off = 0; off < (s ? 8 : 4); off += (1 << sz)) begin
          logic [63:0] rd, wd;
          logic [31:0] a, ea;
          bit sg;
          int w, nb;
          nb = s ? 8 : 4;
          rd = {$urandom, $urandom};
          wd = {$urandom, $urandom};
          if (s == 0) begin rd[63:32] = '0; wd[63:32] = '0; end
          sg = 1'($urandom_range(0, 1));
          w  = $urandom_range(0, 2);
          a  = 32'h0000_8000 + 32'($urandom_range(0, 15) * 8) + 32'(off);
          ea = a & ~32'(nb - 1);
          access("lane_ld", s[0], 0, sz[1:0], sg, a, wd, rd, w, ea, m_be(off, sz),
                 m_wd(wd, off, nb), m_load(rd, off, sz, sg, nb), 2'd0);
          access("lane_st", s[0], 1, sz[1:0], sg, a, wd, rd, w, ea, m_be(off, sz),
                 m_wd(wd, off, nb), 64'h0, 2'd0);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    @(negedge clk);
    t_valid = 1'b1; t_we = 1'b1; t_sz = 2'd2; t_addr = 32'h6000; t_wd = 64'h5555_AAAA;
    @(negedge clk);
    t_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (o_breq !== 1'b1) $display("FAIL rst_mid_busy: got bus_req=%b want 1", o_breq);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    chk_cnt++;
    if ({m32.resp_valid, m32.resp_rdata, m32.resp_exc, m32.bus_req, m32.bus_we, m32.bus_addr,
         m32.bus_be, m32.bus_wdata} !== '0)
      $display("FAIL rst_mid_async: got bus_req=%b be=%h wd=%h want all zero",
               m32.bus_req, m32.bus_be, m32.bus_wdata);
    else pass_cnt++;
    t_ack = 1'b1; t_rd = 64'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    t_ack = 1'b0; t_rd = '0;
    chk_cnt++;
    if ({o_rvalid, o_breq, o_ready} !== 3'b001)
      $display("FAIL rst_mid_stale_ack: got valid=%b bus_req=%b ready=%b want 0 0 1",
               o_rvalid, o_breq, o_ready);
    else pass_cnt++;
    access("after_reset", 0, 0, 2'd1, 0, 32'h6002, 64'h0, 64'h9ABC_0000, 1,
           32'h6000, 8'h0C, 64'h0, 64'h0000_9ABC, 2'd0);
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_exceptions();
    test_timeout();
    test_wide();
    test_lanes();
    test_reset_mid();
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle load/store unit between the MEM stage and the data bus; successor to the combinational load-extension block.
- Generalised to 32/64-bit data, with store byte-enable/lane generation, alignment checking, a req/ack bus handshake with wait states, and a bus timeout.
- Returns the extended load data, or an exception code, to the pipeline as a one-cycle response.

Parameters:
DATA_W, 32, bus/data width; legal values are 32 and 64
ADDR_W, 32, address width
TIMEOUT, 255, bus cycles without ack before a timeout error; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  pipeline access request
req_ready  out  1  unit idle; request accepted when req_valid and req_ready are both high
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 byte, 1 half, 2 word, 3 dword
req_signed  in  1  load sign-extend (1) or zero-extend (0)
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_exc  out  2  0 none, 1 misaligned, 2 bus timeout, 3 illegal size
bus_req  out  1  bus request, held until ack or timeout
bus_we  out  1  bus write
bus_addr  out  ADDR_W  address aligned to DATA_W/8 bytes
bus_be  out  DATA_W/8  byte enables
bus_wdata  out  DATA_W  store data shifted into its byte lane
bus_ack  in  1  bus completion, sampled on the rising edge
bus_rdata  in  DATA_W  read data, valid in the ack cycle

Behaviour:
- Reset: state IDLE; req_ready=1; every other output 0; wait counter cleared. Asserting reset mid-transaction drops bus_req immediately, no response is issued, and any later bus_ack is ignored.
- States:
  - IDLE: on accept, capture we/size/signed/addr/wdata. Then go to RESP with exc=3 if size=3 and DATA_W=32; else RESP with exc=1 if addr is not a multiple of 2^size; else BUS.
  - BUS: bus_req=1, outputs stable. On bus_ack=1: latch bus_rdata, go to RESP with exc=0.
  - Timeout (TIMEOUT≠0): after TIMEOUT consecutive BUS cycles without ack, drop bus_req and go to RESP with exc=2. An ack in the final cycle wins over the timeout.
  - RESP: resp_valid=1 for exactly one cycle, then back to IDLE.
- req_ready is 1 only in IDLE; bus_ack outside BUS is ignored.
- Latency:
  - Ack in the first BUS cycle: resp_valid two cycles after the accept edge.
  - Each wait cycle adds one cycle.
  - Exceptions: resp_valid one cycle after accept, with no bus activity.
- Lane rules (off = addr[log2(DATA_W/8)-1:0], n = 2^size):
  - bus_addr = addr with the low off bits cleared.
  - bus_be = ((1<<n)-1) << off for both loads and stores.
  - bus_wdata = req_wdata << (8*off).
- Load data: shift latched rdata right by 8*off, keep the low 8n bits, then sign-extend (bit 8n-1) if signed, else zero-extend to DATA_W. A dword ignores req_signed.
- resp_rdata and resp_exc are held until the next accept and are meaningful only while resp_valid=1.
- Wait counter clears on every accept and is sized to hold TIMEOUT.

Test Plan:
1. DATA_W=32, signed byte load at addr 0x1003, ack in the first cycle, bus_rdata=0x80FF_FFFF -> bus_addr=0x1000, bus_be=4'b1000, resp_rdata=0xFFFF_FF80, exc=0, resp_valid two cycles after accept.
2. DATA_W=32, store half at 0x2002, wdata=0x0000_ABCD, ack after 3 wait cycles -> bus_be=4'b1100, bus_wdata=0xABCD_0000, bus_req high for 4 cycles, resp_valid the cycle after ack, rdata=0.
3. Misaligned word load at 0x3002 -> bus_req never asserted, resp_valid one cycle later with exc=1; size=3 on DATA_W=32 -> exc=3.
4. TIMEOUT=4, no ack -> bus_req high exactly 4 cycles, then resp_valid with exc=2; repeat with ack in the 4th cycle -> exc=0 with data.
5. DATA_W=64, unsigned word load at 0x4004, bus_rdata=0x8765_4321_0000_0000 -> bus_be=8'hF0, resp_rdata=0x0000_0000_8765_4321; signed -> 0xFFFF_FFFF_8765_4321.
6. Reset asserted during BUS wait -> bus_req and all outputs 0 asynchronously, req_ready=1 after release, stale ack ignored, next access completes normally.
